// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch front-end: FSM states, exception codes,
// the hold-buffer entry layout and a saturating add for the optional perf counters.
package fetch_pkg;
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD, S_ERR} state_t;

  localparam logic [1:0] IEXC_NONE     = 2'd1;
  localparam logic [1:0] IEXC_ADEL     = 2'd2;
  localparam logic [2:0] UNCACHED_BASE = 3'b101;

  typedef struct packed {
    logic [31:0] inst1;
    logic [31:0] inst2;
    logic [31:0] pc;
    logic        two;
    logic        cached;
  } hold_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch request/response bus between the fetch unit and the I-cache/uncached bridge.
interface inst_fetch_if;
  logic        ireq_valid;
  logic        ireq_ready;
  logic [31:0] ireq_addr;
  logic        ireq_cached;
  logic        ireq_two;
  logic        irsp_valid;
  logic [31:0] irsp_inst1;
  logic [31:0] irsp_inst2;

  modport master (output ireq_valid, ireq_addr, ireq_cached, ireq_two,
                  input  ireq_ready, irsp_valid, irsp_inst1, irsp_inst2);
  modport slave  (input  ireq_valid, ireq_addr, ireq_cached, ireq_two,
                  output ireq_ready, irsp_valid, irsp_inst1, irsp_inst2);
endinterface

// File: rtl/inst_fetch_hold_buf.sv
// One-entry skid register that parks a fetch response while the instruction FIFO is full.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  aresetn,
  input  logic  load,
  input  logic  clear,
  input  logic  unload,
  input  hold_t d,
  output hold_t q,
  output logic  valid
);
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear || unload) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// PC generator / one-outstanding fetch requester feeding the dual-issue instruction FIFO.
// Optional macro FETCH_PERF_EN adds saturating perf counters and their output ports.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'hBFC0_0000,
  parameter logic [2:0]  UNCACHED_BASE = fetch_pkg::UNCACHED_BASE
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        gotoBranch,
  input  logic [31:0] branch_target,
  input  logic        fifoFull,
  inst_fetch_if.master ibus,
  output logic [31:0] pc,
  output logic [31:0] inst1,
  output logic [31:0] inst2,
  output logic        write1En,
  output logic        write2En,
  output logic [1:0]  iexcep,
  output logic        cached
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_words,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_discards
`endif
);
  state_t      state, state_nx;
  logic [31:0] fetch_pc;
  logic        redirect, aligned, cur_cached, cur_two, accept;
  logic        emit, emit_hold, adel, drop, hb_load, hb_clear, hb_valid;
  logic [31:0] target;
  hold_t       rsp, hb_q, src;

  assign redirect   = flush | gotoBranch;
  assign target     = flush ? flush_pc : branch_target;
  assign aligned    = (fetch_pc[1:0] == 2'b00);
  assign cur_cached = (fetch_pc[31:29] != UNCACHED_BASE);
  assign cur_two    = cur_cached & ~fetch_pc[2];

  assign ibus.ireq_valid  = aresetn && (state == S_REQ) && aligned;
  assign ibus.ireq_addr   = fetch_pc;
  assign ibus.ireq_cached = cur_cached;
  assign ibus.ireq_two    = cur_two;
  assign accept           = ibus.ireq_valid & ibus.ireq_ready;

  // fetch_pc is frozen while WAIT is pending, so it still describes the outstanding request
  assign rsp = '{inst1: ibus.irsp_inst1, inst2: ibus.irsp_inst2, pc: fetch_pc,
                 two: cur_two, cached: cur_cached};
  assign src = emit_hold ? hb_q : rsp;

  fetch_hold_buf u_hold (
    .clk(clk), .aresetn(aresetn), .load(hb_load), .clear(hb_clear),
    .unload(emit_hold), .d(rsp), .q(hb_q), .valid(hb_valid)
  );

  always_comb begin
    state_nx  = state;
    emit      = 1'b0;
    emit_hold = 1'b0;
    adel      = 1'b0;
    drop      = 1'b0;
    hb_load   = 1'b0;
    hb_clear  = 1'b0;
    case (state)
      S_REQ: begin
        if (!aligned) begin
          adel     = 1'b1;
          state_nx = S_ERR;
        end else if (accept) state_nx = S_WAIT;
      end
      S_WAIT: if (ibus.irsp_valid) begin
        if (fifoFull) begin
          hb_load  = 1'b1;
          state_nx = S_HOLD;
        end else begin
          emit     = 1'b1;
          state_nx = S_REQ;
        end
      end
      S_HOLD: if (!fifoFull && hb_valid) begin
        emit      = 1'b1;
        emit_hold = 1'b1;
        state_nx  = S_REQ;
      end
      S_DISCARD: if (ibus.irsp_valid) begin
        drop     = 1'b1;
        state_nx = S_REQ;
      end
      default: ;
    endcase
    // A redirect kills any write this cycle; only an in-flight request forces DISCARD
    if (redirect) begin
      emit      = 1'b0;
      emit_hold = 1'b0;
      adel      = 1'b0;
      hb_load   = 1'b0;
      hb_clear  = 1'b1;
      case (state)
        S_REQ:     state_nx = accept ? S_DISCARD : S_REQ;
        S_WAIT: begin
          drop     = ibus.irsp_valid;
          state_nx = ibus.irsp_valid ? S_REQ : S_DISCARD;
        end
        S_HOLD: begin
          drop     = 1'b1;
          state_nx = S_REQ;
        end
        S_DISCARD: state_nx = ibus.irsp_valid ? S_REQ : S_DISCARD;
        default:   state_nx = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      pc       <= '0;
      inst1    <= '0;
      inst2    <= '0;
      write1En <= 1'b0;
      write2En <= 1'b0;
      iexcep   <= IEXC_NONE;
      cached   <= 1'b0;
    end else begin
      state    <= state_nx;
      write1En <= emit | adel;
      write2En <= emit & src.two;
      if (redirect)  fetch_pc <= target;
      else if (emit) fetch_pc <= fetch_pc + (src.two ? 32'd8 : 32'd4);
      if (emit) begin
        pc     <= src.pc;
        inst1  <= src.inst1;
        inst2  <= src.inst2;
        cached <= src.cached;
        iexcep <= IEXC_NONE;
      end else if (adel) begin
        pc     <= fetch_pc;
        inst1  <= '0;
        inst2  <= '0;
        cached <= cur_cached;
        iexcep <= IEXC_ADEL;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      perf_fetch_words <= '0;
      perf_full_cycles <= '0;
      perf_discards    <= '0;
    end else begin
      perf_fetch_words <= sat_add(perf_fetch_words,
                                  emit ? (src.two ? 2'd2 : 2'd1) : {1'b0, adel});
      perf_full_cycles <= sat_add(perf_full_cycles, {1'b0, state == S_HOLD});
      perf_discards    <= sat_add(perf_discards, {1'b0, drop});
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: acts as the I-cache bridge and checks FIFO writes.
module tb_inst_fetch;
  logic        clk = 1'b0, aresetn = 1'b0;
  logic        flush = 1'b0, gotoBranch = 1'b0, fifoFull = 1'b0;
  logic [31:0] flush_pc = '0, branch_target = '0;
  logic [31:0] pc, inst1, inst2;
  logic        write1En, write2En, cached;
  logic [1:0]  iexcep;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_words, perf_full_cycles, perf_discards;
`endif
  int n_cmp = 0, n_err = 0;

  inst_fetch_if ibus();

  inst_fetch dut (
    .clk(clk), .aresetn(aresetn), .flush(flush), .flush_pc(flush_pc),
    .gotoBranch(gotoBranch), .branch_target(branch_target), .fifoFull(fifoFull),
    .ibus(ibus), .pc(pc), .inst1(inst1), .inst2(inst2), .write1En(write1En),
    .write2En(write2En), .iexcep(iexcep), .cached(cached)
`ifdef FETCH_PERF_EN
    , .perf_fetch_words(perf_fetch_words), .perf_full_cycles(perf_full_cycles),
    .perf_discards(perf_discards)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full fetch transaction: wait, optional stall with ready=0, accept,
  // respond after lat cycles (optionally into a full FIFO), then check the write.
  task automatic fetch(input logic [31:0] a, input logic c, input logic t,
                       input int hold, input int lat, input int full,
                       input logic [31:0] i1, input logic [31:0] i2);
    int n = 0;
    while (!ibus.ireq_valid && n < 10) begin step(); n++; end
    chk("req_valid", {31'd0, ibus.ireq_valid}, 32'd1);
    chk("req_addr", ibus.ireq_addr, a);
    chk("req_cached", {31'd0, ibus.ireq_cached}, {31'd0, c});
    chk("req_two", {31'd0, ibus.ireq_two}, {31'd0, t});
    repeat (hold) begin
      step();
      chk("req_stable_addr", ibus.ireq_addr, a);
      chk("req_stable_two", {31'd0, ibus.ireq_two}, {31'd0, t});
    end
    ibus.ireq_ready = 1'b1;
    step();
    ibus.ireq_ready = 1'b0;
    chk("req_dropped", {31'd0, ibus.ireq_valid}, 32'd0);
    repeat (lat) step();
    ibus.irsp_valid = 1'b1;
    ibus.irsp_inst1 = i1;
    ibus.irsp_inst2 = i2;
    fifoFull = (full > 0);
    step();
    ibus.irsp_valid = 1'b0;
    ibus.irsp_inst1 = 32'hFFFF_FFFF;
    ibus.irsp_inst2 = 32'hFFFF_FFFF;
    if (full > 0) begin
      repeat (full) begin
        chk("no_wr_when_full", {31'd0, write1En}, 32'd0);
        step();
      end
      fifoFull = 1'b0;
      step();
    end
    chk("wr1", {31'd0, write1En}, 32'd1);
    chk("wr2", {31'd0, write2En}, {31'd0, t});
    chk("wr_pc", pc, a);
    chk("wr_inst1", inst1, i1);
    if (t) chk("wr_inst2", inst2, i2);
    chk("wr_iexcep", {30'd0, iexcep}, 32'd1);
    chk("wr_cached", {31'd0, cached}, {31'd0, c});
    step();
    chk("wr_pulse", {31'd0, write1En}, 32'd0);
  endtask

  initial begin
    ibus.ireq_ready = 1'b0;
    ibus.irsp_valid = 1'b0;
    ibus.irsp_inst1 = '0;
    ibus.irsp_inst2 = '0;
    repeat (2) step();
    chk("rst_wr1", {31'd0, write1En}, 32'd0);
    chk("rst_wr2", {31'd0, write2En}, 32'd0);
    chk("rst_iexcep", {30'd0, iexcep}, 32'd1);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req_valid", {31'd0, ibus.ireq_valid}, 32'd0);
    aresetn = 1'b1;

    // 1: reset PC is kseg1 -> uncached single word
    fetch(32'hBFC0_0000, 1'b0, 1'b0, 2, 2, 0, 32'h1111_0001, 32'h1111_0002);
    chk("next_after_uncached", ibus.ireq_addr, 32'hBFC0_0004);

    // 2: branch into cached space, dual-word fetch
    gotoBranch = 1'b1; branch_target = 32'h8000_0010;
    step();
    gotoBranch = 1'b0;
    chk("br_no_write", {31'd0, write1En}, 32'd0);
    fetch(32'h8000_0010, 1'b1, 1'b1, 0, 1, 0, 32'h2222_0001, 32'h2222_0002);

    // 3: response lands while FIFO full, held data written later
    fetch(32'h8000_0018, 1'b1, 1'b1, 0, 1, 3, 32'h3333_0001, 32'h3333_0002);

    // 4: redirect while waiting: stale response dropped
    chk("pre_discard_addr", ibus.ireq_addr, 32'h8000_0020);
    ibus.ireq_ready = 1'b1;
    step();
    ibus.ireq_ready = 1'b0;
    step();
    gotoBranch = 1'b1; branch_target = 32'h8000_0100;
    step();
    gotoBranch = 1'b0;
    chk("discard_no_req", {31'd0, ibus.ireq_valid}, 32'd0);
    chk("discard_no_wr", {31'd0, write1En}, 32'd0);
    ibus.irsp_valid = 1'b1; ibus.irsp_inst1 = 32'hDEAD_BEEF;
    step();
    ibus.irsp_valid = 1'b0;
    chk("stale_dropped", {31'd0, write1En}, 32'd0);
    fetch(32'h8000_0100, 1'b1, 1'b1, 0, 1, 0, 32'h4444_0001, 32'h4444_0002);

    // 5: misaligned target -> AdEL write then idle until flush
    gotoBranch = 1'b1; branch_target = 32'h8000_0102;
    step();
    gotoBranch = 1'b0;
    chk("adel_no_req", {31'd0, ibus.ireq_valid}, 32'd0);
    step();
    chk("adel_wr1", {31'd0, write1En}, 32'd1);
    chk("adel_wr2", {31'd0, write2En}, 32'd0);
    chk("adel_iexcep", {30'd0, iexcep}, 32'd2);
    chk("adel_pc", pc, 32'h8000_0102);
    chk("adel_inst1", inst1, 32'd0);
    step();
    chk("adel_pulse", {31'd0, write1En}, 32'd0);
    repeat (3) step();
    chk("err_idle", {31'd0, ibus.ireq_valid}, 32'd0);
    flush = 1'b1; flush_pc = 32'hBFC0_0380;
    step();
    flush = 1'b0;
    fetch(32'hBFC0_0380, 1'b0, 1'b0, 0, 2, 0, 32'h5555_0001, 32'h5555_0002);

    // 6: flush beats a simultaneous branch
    flush = 1'b1; flush_pc = 32'h8000_0200;
    gotoBranch = 1'b1; branch_target = 32'h8000_0300;
    step();
    flush = 1'b0; gotoBranch = 1'b0;
    fetch(32'h8000_0200, 1'b1, 1'b1, 0, 1, 0, 32'h6666_0001, 32'h6666_0002);
    chk("final_next_addr", ibus.ireq_addr, 32'h8000_0208);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
